cell_state_buffer: RTL and testbench

- Banked register store for per-cell layer state.
- Depth per bank is set by FRT_CELL/MID_CELL: 2*FRT_CELL*MID_CELL + 2*FRT_CELL entries.
- Adds registered read, write-ready backpressure, and a programmable sequential clear engine that zeroes one entry per cycle instead of a combinational loop.
- Sits between the cell compute datapath and downstream readout logic.

---
 rtl/cell_buf_pkg.sv | 30 +++
 rtl/csb_clear_fsm.sv | 82 ++++++++
 rtl/cell_state_buffer.sv | 133 +++++++++++++
 tb/tb_cell_state_buffer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_buf_pkg.sv
// Shared sizing helpers, clear-engine state type and the default mid-layer clear region
// for the banked cell state buffer.
package cell_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  function automatic int csb_depth(input int frt_cell, input int mid_cell);
    return 2 * frt_cell * mid_cell + 2 * frt_cell;
  endfunction

  function automatic int csb_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int csb_bank_w(input int num_bank);
    return (num_bank > 1) ? $clog2(num_bank) : 1;
  endfunction

  localparam int DEF_FRT_CELL = 32;
  localparam int DEF_MID_CELL = 20;

  // Mid-layer region sits after the two front-layer blocks
  localparam int MID_BASE = 2 * DEF_FRT_CELL;
  localparam int MID_LEN  = DEF_FRT_CELL * DEF_MID_CELL;

endpackage

// File: rtl/csb_clear_fsm.sv
// Sequential clear engine: zeroes one entry per cycle from base, truncating at the array end.
// Latency: busy the cycle after clr_req, one write per CLEAR cycle, clr_done pulse in DONE.
// Backpressure: clr_req while busy is dropped; no queueing.
module csb_clear_fsm
  import cell_buf_pkg::*;
#(
  parameter int DEPTH  = 1344,
  parameter int ADDR_W = 11,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W:0]   clr_len,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [BANK_W-1:0] clr_bank_q,
  output logic [ADDR_W-1:0] clr_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  clr_state_t          state;
  logic [ADDR_W:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      clr_we     <= 1'b0;
      clr_bank_q <= '0;
      clr_ptr    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            clr_bank_q <= clr_bank;
            clr_ptr    <= clr_base;
            cnt        <= clr_len;
            clr_busy   <= 1'b1;
            if (clr_len == '0) begin
              state    <= DONE;
              clr_done <= 1'b1;
            end else begin
              state    <= CLEAR;
              clr_we   <= 1'b1;
            end
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          cnt     <= cnt - 1'b1;
          // Stop on the last requested entry or at the array end, whichever comes first
          if (cnt == CNT_ONE || clr_ptr == LAST_ADDR) begin
            state    <= DONE;
            clr_we   <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
          clr_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cell_state_buffer.sv
// Banked per-cell layer state store with registered read and a sequential clear engine.
// Latency: read data/valid one cycle after rd_en; reads never stall. Build option CSB_PARITY_EN adds per-entry parity.
// Backpressure: wr_rdy drops only for writes targeting the bank currently being cleared.
module cell_state_buffer
  import cell_buf_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRT_CELL = 32,
  parameter int MID_CELL = 20,
  parameter int BCK_CELL = 10,
  parameter int NUM_BANK = 3,
  localparam int DEPTH   = csb_depth(FRT_CELL, MID_CELL),
  localparam int ADDR_W  = csb_addr_w(DEPTH),
  localparam int BANK_W  = csb_bank_w(NUM_BANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              rd_en,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  input  logic [BANK_W-1:0] clr_bank,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W:0]   clr_len,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rd_perr
);

`ifdef CSB_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  localparam logic [BANK_W:0] BANK_LIM = (BANK_W + 1)'(NUM_BANK);
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH);

  // Back-layer count does not size the store; only a sanity bound is enforced
  if (NUM_BANK < 1 || BCK_CELL < 0) begin : g_bad_cfg
    $error("cell_state_buffer: NUM_BANK must be >= 1 and BCK_CELL >= 0");
  end

  logic [ENTRY_W-1:0] mem [NUM_BANK][DEPTH];

  logic              clr_we;
  logic [BANK_W-1:0] clr_bank_q;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_hit;
  logic              clr_hit;
  logic              rd_hit;
  logic [ENTRY_W-1:0] wr_word;
  logic [ENTRY_W-1:0] rd_word;

  csb_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_bank   (clr_bank),
    .clr_base   (clr_base),
    .clr_len    (clr_len),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clr_we     (clr_we),
    .clr_bank_q (clr_bank_q),
    .clr_ptr    (clr_ptr)
  );

  assign wr_rdy  = !(clr_busy && (wr_bank == clr_bank_q));
  assign wr_hit  = wr_en && wr_rdy && ({1'b0, wr_bank} < BANK_LIM) && ({1'b0, wr_addr} < ADDR_LIM);
  // Out-of-range clear bank still runs the FSM for timing but never touches the array
  assign clr_hit = clr_we && ({1'b0, clr_bank_q} < BANK_LIM) && ({1'b0, clr_ptr} < ADDR_LIM);
  assign rd_hit  = ({1'b0, rd_bank} < BANK_LIM) && ({1'b0, rd_addr} < ADDR_LIM);

`ifdef CSB_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = mem[rd_bank][rd_addr];
    end
  end

  // Write and clear never target the same bank: wr_rdy blocks the bank under clear
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_bank][wr_addr] <= wr_word;
    end
    if (clr_hit) begin
      mem[clr_bank_q][clr_ptr] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word[DATA_W-1:0];
      end
    end
  end

`ifdef CSB_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_perr <= 1'b0;
    end else begin
      rd_perr <= rd_en && (^rd_word);
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_cell_state_buffer.sv
// Randomized scoreboard bench for cell_state_buffer against an array-and-queue reference model.
module tb_cell_state_buffer;
  import cell_buf_pkg::*;

  localparam int DEPTH = 1344;
  localparam int NB    = 3;
  localparam int AW    = 11;
  localparam int BW    = 2;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [BW-1:0] wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy;
  logic          rd_en;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_req;
  logic [BW-1:0] clr_bank;
  logic [AW-1:0] clr_base;
  logic [AW:0]   clr_len;
  logic          clr_busy;
  logic          clr_done;
  logic          rd_perr;

  cell_state_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .rd_en    (rd_en),
    .rd_bank  (rd_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .clr_req  (clr_req),
    .clr_bank (clr_bank),
    .clr_base (clr_base),
    .clr_len  (clr_len),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .rd_perr  (rd_perr)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: plain contents array plus a list of addresses still to be cleared
  logic [DW-1:0] ref_mem [NB][DEPTH];
  bit            ref_bad [NB][DEPTH];
  int            clr_q[$];
  bit            m_active = 0;
  bit            m_done   = 0;
  logic [BW-1:0] m_bank   = '0;

  logic [DW-1:0] exp_dat_q[$];
  bit            exp_perr_q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_bank = '0; rd_addr = '0;
    clr_req = 0; clr_bank = '0; clr_base = '0; clr_len = '0;
  endtask

  // Apply current inputs for one clock edge and advance the model alongside it
  task automatic step();
    bit rdy_exp;
    int n;
    int a;
    rdy_exp = !(m_active && (wr_bank == m_bank));
    #2;
    check("wr_rdy", wr_rdy, rdy_exp);
    if (rd_en) begin
      if (rd_bank < NB && rd_addr < DEPTH) begin
        exp_dat_q.push_back(ref_mem[rd_bank][rd_addr]);
        exp_perr_q.push_back(ref_bad[rd_bank][rd_addr]);
      end else begin
        exp_dat_q.push_back('0);
        exp_perr_q.push_back(1'b0);
      end
    end
    if (m_active) begin
      if (clr_q.size() > 0) begin
        a = clr_q.pop_front();
        if (m_bank < NB && a < DEPTH) begin
          ref_mem[m_bank][a] = '0;
          ref_bad[m_bank][a] = 1'b0;
        end
        if (clr_q.size() == 0) m_done = 1;
      end else begin
        m_done   = 0;
        m_active = 0;
      end
    end else if (clr_req) begin
      m_bank   = clr_bank;
      m_active = 1;
      n = (int'(clr_len) > DEPTH - int'(clr_base)) ? DEPTH - int'(clr_base) : int'(clr_len);
      for (int i = 0; i < n; i++) clr_q.push_back(int'(clr_base) + i);
      m_done = (n == 0);
    end
    if (wr_en && rdy_exp && wr_bank < NB && wr_addr < DEPTH) begin
      ref_mem[wr_bank][wr_addr] = wr_data;
      ref_bad[wr_bank][wr_addr] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("clr_busy", clr_busy, m_active);
    check("clr_done", clr_done, m_done);
  endtask

  task automatic read_range(input int b, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      idle_inputs();
      rd_en = 1; rd_bank = BW'(b); rd_addr = AW'(a);
      step();
    end
  endtask

  // Scoreboard monitor: pops one expectation per presented read, otherwise checks hold
  initial begin
    logic [DW-1:0] ed;
    bit            ep;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_valid) begin
          if (exp_dat_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_valid_unexpected: got rd_valid=1 with data %0h, required no read pending", rd_data);
          end else begin
            ed = exp_dat_q.pop_front();
            ep = exp_perr_q.pop_front();
            check("rd_data", rd_data, ed);
            check("rd_perr", rd_perr, ep);
            last_rd = ed;
          end
        end else begin
          check("rd_hold", rd_data, last_rd);
          check("rd_perr_idle", rd_perr, 1'b0);
        end
      end
    end
  end

  initial begin
    int busy_cyc;
    int done_cnt;
    idle_inputs();
    rst_n = 0;
    #3;
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_rd_perr", rd_perr, 0);
    #18 rst_n = 1;
    @(posedge clk); #1;

    for (int b = 0; b < NB; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        idle_inputs();
        wr_en = 1; wr_bank = BW'(b); wr_addr = AW'(a);
        wr_data = (b == 0) ? 16'hFFFF : DW'($urandom);
        step();
      end
    end

    idle_inputs();
    wr_en = 1; wr_bank = 1; wr_addr = 1000; wr_data = 16'hBEEF;
    step();
    read_range(1, 1000, 1000);
    idle_inputs();
    step();

    // Mid-layer clear of bank0 with contending writes to bank0 and bank2
    idle_inputs();
    clr_req = 1; clr_bank = 0; clr_base = AW'(MID_BASE); clr_len = (AW + 1)'(MID_LEN);
    step();
    busy_cyc = 0;
    done_cnt = 0;
    for (int g = 0; g < 2000; g++) begin
      if (!clr_busy) break;
      busy_cyc++;
      if (clr_done) done_cnt++;
      idle_inputs();
      if (g == 10) begin wr_en = 1; wr_bank = 0; wr_addr = 900; wr_data = 16'h1234; end
      if (g == 11) begin wr_en = 1; wr_bank = 2; wr_addr = 100; wr_data = 16'h5A5A; end
      if (g == 12) begin rd_en = 1; rd_bank = 0; rd_addr = 5; end
      step();
    end
    check("clear_busy_cycles", busy_cyc, 641);
    check("clear_done_pulses", done_cnt, 1);
    read_range(0, 62, 705);
    read_range(0, 900, 900);
    read_range(2, 100, 100);

    // Clear truncated at the array end
    idle_inputs();
    clr_req = 1; clr_bank = 1; clr_base = 1340; clr_len = 10;
    step();
    busy_cyc = 0;
    for (int g = 0; g < 100; g++) begin
      if (!clr_busy) break;
      busy_cyc++;
      idle_inputs();
      step();
    end
    check("trunc_busy_cycles", busy_cyc, 5);
    read_range(1, 1336, 1343);
    read_range(1, 0, 3);

    // Zero-length clear and out-of-range bank clear
    idle_inputs();
    clr_req = 1; clr_bank = 2; clr_base = 10; clr_len = 0;
    step();
    idle_inputs(); step(); step();
    clr_req = 1; clr_bank = 3; clr_base = 20; clr_len = 5;
    step();
    for (int g = 0; g < 8; g++) begin idle_inputs(); step(); end
    read_range(0, 18, 26);

    // Reset after 100 clear writes into bank2
    idle_inputs();
    clr_req = 1; clr_bank = 2; clr_base = AW'(MID_BASE); clr_len = (AW + 1)'(MID_LEN);
    step();
    for (int g = 0; g < 100; g++) begin idle_inputs(); step(); end
    rst_n = 0;
    m_active = 0; m_done = 0; clr_q.delete();
    exp_dat_q.delete(); exp_perr_q.delete(); last_rd = '0;
    #2;
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_clr_busy", clr_busy, 0);
    check("midrst_clr_done", clr_done, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("postrst_clr_busy", clr_busy, 0);
    check("postrst_clr_done", clr_done, 0);
    read_range(2, 60, 170);

`ifdef CSB_PARITY_EN
    dut.mem[1][5] = dut.mem[1][5] ^ 17'h0008;
    ref_mem[1][5] = ref_mem[1][5] ^ 16'h0008;
    ref_bad[1][5] = 1'b1;
    read_range(1, 4, 6);
`endif

    // Randomized traffic with same-address collisions and overlapping clear requests
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      wr_en   = 1'($urandom_range(0, 1));
      wr_bank = BW'($urandom_range(0, 3));
      wr_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 2047)) : AW'($urandom_range(0, DEPTH - 1));
      wr_data = DW'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rd_bank = wr_bank; rd_addr = wr_addr;
      end else begin
        rd_bank = BW'($urandom_range(0, 3));
        rd_addr = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 2047)) : AW'($urandom_range(0, DEPTH - 1));
      end
      if ($urandom_range(0, 39) == 0) begin
        clr_req  = 1;
        clr_bank = BW'($urandom_range(0, 3));
        clr_base = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH - 20, DEPTH - 1)) : AW'($urandom_range(0, DEPTH - 1));
        clr_len  = (AW + 1)'($urandom_range(0, 40));
      end
      step();
    end

    idle_inputs();
    for (int g = 0; g < 60; g++) step();
    read_range(0, 0, 40);
    idle_inputs();
    step(); step();
    check("scoreboard_drained", exp_dat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
